ttt_turn_ctrl: RTL and testbench

Turn controller and move arbiter for the tic-tac-toe board: accepts move requests from player X and player O, grants only the player whose turn it is, rejects illegal or occupied cells, and drives the 4-bit cell select and write strobe into the cell-enable decoder. It keeps its own 9-cell occupancy/ownership copy of the board, detects win and draw after every move, and freezes the game until a new-game request.

---
 rtl/ttt_turn_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_ttt_turn_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_turn_ctrl.sv
// ttt_turn_ctrl: turn controller and move arbiter for a 3x3 tic-tac-toe board.
// Grants moves only to the player whose turn it is, rejects out-of-range or
// occupied cells, drives the cell-enable decoder (sel/wr_en/wr_mark), keeps a
// private copy of the board, detects win/draw and freezes until new_game.
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES idle cycles in WAIT; without it timeout is tied low.
module ttt_turn_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       req_x,
  input  logic       req_o,
  input  logic [3:0] pos_x,
  input  logic [3:0] pos_o,
  output logic       ack_x,
  output logic       ack_o,
  output logic       rej_x,
  output logic       rej_o,
  output logic [3:0] sel,
  output logic       wr_en,
  output logic [1:0] wr_mark,
  output logic       turn,
  output logic       win_x,
  output logic       win_o,
  output logic       draw,
  output logic       game_over,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_CHECK,
    S_WRITE,
    S_EVAL,
    S_OVER
  } state_e;

  state_e          state_q;
  logic [8:0][1:0] board_q;
  logic [3:0]      pos_q;
  logic            turn_q;
  logic            win_x_q;
  logic            win_o_q;
  logic            draw_q;
  logic            wr_en_q;
  logic [1:0]      wr_mark_q;
  logic            ack_x_q;
  logic            ack_o_q;

  logic            cur_req;
  logic [3:0]      cur_pos;
  logic [1:0]      mark;
  logic [15:0]     occ;
  logic            pos_bad;
  logic            full;
  logic            won;

  function automatic logic three(input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic [1:0] m);
    return (a == m) && (b == m) && (c == m);
  endfunction

  assign cur_req = turn_q ? req_o : req_x;
  assign cur_pos = turn_q ? pos_o : pos_x;
  assign mark    = turn_q ? 2'b10 : 2'b01;

  // Occupancy padded to 16 entries so any 4-bit pos_q indexes it safely.
  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      occ[i] = |board_q[i];
    end
  end

  assign pos_bad = (pos_q > 4'd8) || occ[pos_q];
  assign full    = &occ[8:0];

  // Eight winning lines checked for the mover's mark.
  always_comb begin
    won = three(board_q[0], board_q[1], board_q[2], mark) |
          three(board_q[3], board_q[4], board_q[5], mark) |
          three(board_q[6], board_q[7], board_q[8], mark) |
          three(board_q[0], board_q[3], board_q[6], mark) |
          three(board_q[1], board_q[4], board_q[7], mark) |
          three(board_q[2], board_q[5], board_q[8], mark) |
          three(board_q[0], board_q[4], board_q[8], mark) |
          three(board_q[2], board_q[4], board_q[6], mark);
  end

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
`endif

  // Main FSM: arbitration, board update, result evaluation, restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      board_q   <= '0;
      pos_q     <= '0;
      turn_q    <= 1'b0;
      win_x_q   <= 1'b0;
      win_o_q   <= 1'b0;
      draw_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_mark_q <= '0;
      ack_x_q   <= 1'b0;
      ack_o_q   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      wr_en_q   <= 1'b0;
      wr_mark_q <= '0;
      ack_x_q   <= 1'b0;
      ack_o_q   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      timeout_q <= 1'b0;
      if (state_q != S_WAIT) begin
        cnt_q <= '0;
      end
`endif
      if (new_game) begin
        // Restart wins over everything, including a pending board write.
        state_q <= S_WAIT;
        board_q <= '0;
        turn_q  <= 1'b0;
        win_x_q <= 1'b0;
        win_o_q <= 1'b0;
        draw_q  <= 1'b0;
`ifdef TURN_TIMEOUT_EN
        cnt_q   <= '0;
`endif
      end else begin
        case (state_q)
          S_WAIT: begin
            if (cur_req) begin
              pos_q   <= cur_pos;
              state_q <= S_CHECK;
`ifdef TURN_TIMEOUT_EN
              cnt_q   <= '0;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
              timeout_q <= 1'b1;
              turn_q    <= ~turn_q;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
`endif
            end
          end
          S_CHECK: begin
            if (pos_bad) begin
              state_q <= S_WAIT;
            end else begin
              state_q   <= S_WRITE;
              wr_en_q   <= 1'b1;
              wr_mark_q <= mark;
              ack_x_q   <= ~turn_q;
              ack_o_q   <= turn_q;
            end
          end
          S_WRITE: begin
            for (int unsigned i = 0; i < 9; i++) begin
              if (pos_q == 4'(i)) begin
                board_q[i] <= mark;
              end
            end
            state_q <= S_EVAL;
          end
          S_EVAL: begin
            if (won) begin
              win_x_q <= ~turn_q;
              win_o_q <= turn_q;
              state_q <= S_OVER;
            end else if (full) begin
              draw_q  <= 1'b1;
              state_q <= S_OVER;
            end else begin
              turn_q  <= ~turn_q;
              state_q <= S_WAIT;
            end
          end
          S_OVER: begin
            state_q <= S_OVER;
          end
          default: begin
            state_q <= S_WAIT;
          end
        endcase
      end
    end
  end

  // Reject is decoded in CHECK so it appears one cycle after the sample edge.
  assign rej_x     = (state_q == S_CHECK) && pos_bad && !turn_q;
  assign rej_o     = (state_q == S_CHECK) && pos_bad && turn_q;
  assign ack_x     = ack_x_q;
  assign ack_o     = ack_o_q;
  assign sel       = pos_q;
  assign wr_en     = wr_en_q;
  assign wr_mark   = wr_mark_q;
  assign turn      = turn_q;
  assign win_x     = win_x_q;
  assign win_o     = win_o_q;
  assign draw      = draw_q;
  assign game_over = win_x_q | win_o_q | draw_q;
`ifdef TURN_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Testbench for ttt_turn_ctrl: vector table of scripted games, hand-written
// corner sequences, then random play checked against a move-level board model.
module tb_ttt_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_game;
  logic       req_x;
  logic       req_o;
  logic [3:0] pos_x;
  logic [3:0] pos_o;
  logic       ack_x;
  logic       ack_o;
  logic       rej_x;
  logic       rej_o;
  logic [3:0] sel;
  logic       wr_en;
  logic [1:0] wr_mark;
  logic       turn;
  logic       win_x;
  logic       win_o;
  logic       draw;
  logic       game_over;
  logic       timeout;

  localparam int OP_X  = 0;
  localparam int OP_O  = 1;
  localparam int OP_NG = 2;
  localparam int K_IGN = 0;
  localparam int K_ACK = 1;
  localparam int K_REJ = 2;

  ttt_turn_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .req_x(req_x), .req_o(req_o), .pos_x(pos_x), .pos_o(pos_o),
    .ack_x(ack_x), .ack_o(ack_o), .rej_x(rej_x), .rej_o(rej_o),
    .sel(sel), .wr_en(wr_en), .wr_mark(wr_mark), .turn(turn),
    .win_x(win_x), .win_o(win_o), .draw(draw), .game_over(game_over),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int op;
    int pos;
    int kind;
    bit t;
    bit wx;
    bit wo;
    bit dr;
  } vec_t;

  vec_t tv[$];

  // Behavioural board model: 0 empty, 1 X, 2 O.
  int mb[9];
  bit mt, mwx, mwo, mdr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit has_line(input int m);
    bit r = 0;
    for (int k = 0; k < 3; k++) begin
      if (mb[3*k] == m && mb[3*k+1] == m && mb[3*k+2] == m) r = 1;
      if (mb[k] == m && mb[k+3] == m && mb[k+6] == m) r = 1;
    end
    if (mb[0] == m && mb[4] == m && mb[8] == m) r = 1;
    if (mb[2] == m && mb[4] == m && mb[6] == m) r = 1;
    return r;
  endfunction

  function automatic int predict(input int op, input int pos);
    if (mwx || mwo || mdr || op != int'(mt)) return K_IGN;
    if (pos > 8) return K_REJ;
    if (mb[pos] != 0) return K_REJ;
    return K_ACK;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mt = 0; mwx = 0; mwo = 0; mdr = 0;
  endtask

  task automatic model_commit(input int op, input int pos, input int kind);
    int m;
    bit full;
    if (op == OP_NG) begin
      model_reset();
    end else if (kind == K_ACK) begin
      m = mt ? 2 : 1;
      mb[pos] = m;
      full = 1;
      for (int i = 0; i < 9; i++) if (mb[i] == 0) full = 0;
      if (has_line(m)) begin
        if (mt) mwo = 1; else mwx = 1;
      end else if (full) begin
        mdr = 1;
      end else begin
        mt = !mt;
      end
    end
  endtask

  task automatic drive_req(input int op, input int pos, input logic v);
    logic [3:0] p;
    p = 4'(pos);
    if (op == OP_X) begin req_x = v; pos_x = p; end
    else            begin req_o = v; pos_o = p; end
  endtask

  // Applies one operation starting and ending at a negedge.
  task automatic do_op(input int op, input int pos, input int kind,
                       input bit et, input bit ewx, input bit ewo, input bit edr);
    if (op == OP_NG) begin
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      chk("ng_wr", {31'd0, wr_en}, 32'd0);
    end else begin
      drive_req(op, pos, 1'b1);
      @(negedge clk);
      if (kind == K_IGN) begin
        for (int k = 0; k < 3; k++) begin
          if (k != 0) @(negedge clk);
          chk("ign_quiet", {27'd0, ack_x, ack_o, rej_x, rej_o, wr_en}, 32'd0);
        end
        drive_req(op, pos, 1'b0);
      end else if (kind == K_REJ) begin
        drive_req(op, pos, 1'b0);
        chk("rej_pulse", {30'd0, rej_x, rej_o}, (op == OP_X) ? 32'd2 : 32'd1);
        chk("rej_noack", {29'd0, ack_x, ack_o, wr_en}, 32'd0);
        @(negedge clk);
        chk("rej_done", {29'd0, rej_x, rej_o, wr_en}, 32'd0);
      end else begin
        drive_req(op, pos, 1'b0);
        chk("chk_quiet", {27'd0, rej_x, rej_o, wr_en, ack_x, ack_o}, 32'd0);
        @(negedge clk);
        chk("wr_en", {31'd0, wr_en}, 32'd1);
        chk("sel", {28'd0, sel}, 32'(pos));
        chk("wr_mark", {30'd0, wr_mark}, (op == OP_X) ? 32'd1 : 32'd2);
        chk("ack", {30'd0, ack_x, ack_o}, (op == OP_X) ? 32'd2 : 32'd1);
        @(negedge clk);
        chk("eval_quiet", {29'd0, wr_en, ack_x, ack_o}, 32'd0);
        @(negedge clk);
      end
    end
    chk("turn", {31'd0, turn}, {31'd0, et});
    chk("flags", {28'd0, win_x, win_o, draw, game_over},
        {28'd0, ewx, ewo, edr, (ewx | ewo | edr)});
  endtask

  task automatic add(input int op, input int pos, input int kind,
                     input bit t, input bit wx, input bit wo, input bit dr);
    vec_t v;
    v.op = op; v.pos = pos; v.kind = kind; v.t = t; v.wx = wx; v.wo = wo; v.dr = dr;
    tv.push_back(v);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[$];
    int tcnt;
    bit allow_ign;
    int op, pos, kind;

    rst_n = 1'b0; new_game = 1'b0; req_x = 1'b0; req_o = 1'b0;
    pos_x = '0; pos_o = '0;
    model_reset();

    // Scripted games.
    add(OP_X, 4, K_ACK, 1, 0, 0, 0);
    add(OP_O, 4, K_REJ, 1, 0, 0, 0);
    add(OP_O, 9, K_REJ, 1, 0, 0, 0);
    add(OP_X, 0, K_IGN, 1, 0, 0, 0);
    add(OP_O, 15, K_REJ, 1, 0, 0, 0);
    add(OP_O, 0, K_ACK, 0, 0, 0, 0);
    add(OP_NG, 0, K_ACK, 0, 0, 0, 0);
    add(OP_X, 0, K_ACK, 1, 0, 0, 0);
    add(OP_O, 3, K_ACK, 0, 0, 0, 0);
    add(OP_X, 1, K_ACK, 1, 0, 0, 0);
    add(OP_O, 4, K_ACK, 0, 0, 0, 0);
    add(OP_X, 2, K_ACK, 0, 1, 0, 0);
    add(OP_O, 5, K_IGN, 0, 1, 0, 0);
    add(OP_X, 5, K_IGN, 0, 1, 0, 0);
    add(OP_NG, 0, K_ACK, 0, 0, 0, 0);
    add(OP_X, 4, K_ACK, 1, 0, 0, 0);
    add(OP_O, 0, K_ACK, 0, 0, 0, 0);
    add(OP_X, 2, K_ACK, 1, 0, 0, 0);
    add(OP_O, 6, K_ACK, 0, 0, 0, 0);
    add(OP_X, 3, K_ACK, 1, 0, 0, 0);
    add(OP_O, 5, K_ACK, 0, 0, 0, 0);
    add(OP_X, 1, K_ACK, 1, 0, 0, 0);
    add(OP_O, 7, K_ACK, 0, 0, 0, 0);
    add(OP_X, 8, K_ACK, 0, 0, 0, 1);
    add(OP_NG, 0, K_ACK, 0, 0, 0, 0);
    add(OP_X, 0, K_ACK, 1, 0, 0, 0);
    add(OP_O, 1, K_ACK, 0, 0, 0, 0);
    add(OP_X, 2, K_ACK, 1, 0, 0, 0);
    add(OP_O, 3, K_ACK, 0, 0, 0, 0);
    add(OP_X, 4, K_ACK, 1, 0, 0, 0);
    add(OP_O, 5, K_ACK, 0, 0, 0, 0);
    add(OP_X, 7, K_ACK, 1, 0, 0, 0);
    add(OP_O, 6, K_ACK, 0, 0, 0, 0);
    add(OP_X, 8, K_ACK, 0, 1, 0, 0);
    add(OP_NG, 0, K_ACK, 0, 0, 0, 0);
    add(OP_X, 0, K_ACK, 1, 0, 0, 0);
    add(OP_O, 3, K_ACK, 0, 0, 0, 0);
    add(OP_X, 1, K_ACK, 1, 0, 0, 0);
    add(OP_O, 4, K_ACK, 0, 0, 0, 0);
    add(OP_X, 8, K_ACK, 1, 0, 0, 0);
    add(OP_O, 5, K_ACK, 1, 0, 1, 0);
    add(OP_NG, 0, K_ACK, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_out", {18'd0, ack_x, ack_o, rej_x, rej_o, sel, wr_en, wr_mark, turn,
                    win_x, win_o, draw, game_over, timeout}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      do_op(tv[i].op, tv[i].pos, tv[i].kind, tv[i].t, tv[i].wx, tv[i].wo, tv[i].dr);
    end

    // Both players request while X is to move: X served, O waits its turn.
    req_x = 1'b1; pos_x = 4'd0; req_o = 1'b1; pos_o = 4'd1;
    @(negedge clk);
    chk("both_norej", {30'd0, rej_x, rej_o}, 32'd0);
    @(negedge clk);
    chk("both_ack", {30'd0, ack_x, ack_o}, 32'd2);
    req_x = 1'b0;
    repeat (4) @(negedge clk);
    chk("both_ack_o", {29'd0, ack_x, ack_o, wr_en}, 32'd3);
    chk("both_mark", {26'd0, sel, wr_mark}, {26'd0, 4'd1, 2'b10});
    req_o = 1'b0;
    repeat (2) @(negedge clk);
    chk("both_turn", {31'd0, turn}, 32'd0);
    do_op(OP_NG, 0, K_ACK, 0, 0, 0, 0);

    // Restart sampled on the edge that would launch the write: no write.
    req_x = 1'b1; pos_x = 4'd2;
    @(negedge clk);
    req_x = 1'b0; new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("ng_chk_wr", {30'd0, wr_en, ack_x}, 32'd0);
    @(negedge clk);
    chk("ng_chk_wr2", {30'd0, wr_en, ack_x}, 32'd0);
    do_op(OP_X, 2, K_ACK, 1, 0, 0, 0);
    do_op(OP_NG, 0, K_ACK, 0, 0, 0, 0);

    // Restart during WRITE: the mark must not be retained.
    req_x = 1'b1; pos_x = 4'd5;
    @(negedge clk);
    req_x = 1'b0;
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
    chk("ng_wr_turn", {31'd0, turn}, 32'd0);
    do_op(OP_X, 5, K_ACK, 1, 0, 0, 0);
    do_op(OP_NG, 0, K_ACK, 0, 0, 0, 0);

    // Asynchronous reset in the WRITE cycle aborts the move.
    req_x = 1'b1; pos_x = 4'd6;
    @(negedge clk);
    req_x = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out", {28'd0, wr_en, ack_x, turn, game_over}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(OP_X, 6, K_ACK, 1, 0, 0, 0);
    do_op(OP_NG, 0, K_ACK, 0, 0, 0, 0);

    // Idle WAIT behaviour.
    tcnt = 0;
`ifdef TURN_TIMEOUT_EN
    allow_ign = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (timeout) tcnt++;
    end
    chk("timeout_pulses", 32'(tcnt), 32'd1);
    chk("timeout_turn", {31'd0, turn}, 32'd1);
    do_op(OP_NG, 0, K_ACK, 0, 0, 0, 0);
`else
    allow_ign = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (timeout) tcnt++;
    end
    chk("no_timeout", 32'(tcnt), 32'd0);
    chk("idle_turn", {31'd0, turn}, 32'd0);
`endif

    // Random play against the board model.
    model_reset();
    for (int n = 0; n < 300; n++) begin
      if ((mwx || mwo || mdr) && $urandom_range(0, 1) == 0) begin
        op = OP_NG;
      end else if (!(mwx || mwo || mdr) && $urandom_range(0, 29) == 0) begin
        op = OP_NG;
      end else if (allow_ign || mwx || mwo || mdr) begin
        op = ($urandom_range(0, 3) == 0) ? int'(!mt) : int'(mt);
      end else begin
        op = int'(mt);
      end
      pos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15))
                                        : int'($urandom_range(0, 8));
      kind = (op == OP_NG) ? K_ACK : predict(op, pos);
      model_commit(op, pos, kind);
      do_op(op, pos, kind, mt, mwx, mwo, mdr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
